cdc_pulse_arb: RTL and testbench

Source-domain scheduler that shares one 1-bit pulse CDC synchronizer (cdc_slow2fast / fast2slow style) between N_REQ requesters. It counts pending request pulses per requester, picks a winner round-robin, and issues single-cycle pulses on `pluse_s` with a guaranteed idle gap so the destination domain never misses or merges pulses. A sideband `pluse_id` names the requester owning each pulse.

---
 rtl/cdc_pulse_arb.sv | 124 ++++++++++++
 tb/tb_cdc_pulse_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_pulse_arb.sv
// Round-robin scheduler sharing one pulse synchronizer among N_REQ requesters.
// Latency: a request sampled at edge k drives pluse_s high after edge k+1.
// Backpressure: requests queue in saturating counters; en low or a running gap holds them back.
module cdc_pulse_arb #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 7,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pls,
    input  logic             en,
    input  logic             ovf_clr,
    output logic             pluse_s,
    output logic [ID_W-1:0]  pluse_id,
    output logic             busy,
    output logic [N_REQ-1:0] ovf
);

    localparam int GC_W = $clog2(GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    logic [CNT_W-1:0] cnt [N_REQ];
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ovf_set;
    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             fire;
    logic [0:0]       state;
    logic [GC_W-1:0]  gap_cnt;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = (cnt[i] != '0);
        end
    end

    // First pending requester at or after rr, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && pend[(int'(rr) + k) % N_REQ]) begin
                winner = ID_W'((int'(rr) + k) % N_REQ);
                found  = 1'b1;
            end
        end
    end

    // A gap counter at zero means the full low gap has elapsed.
    assign fire = en && found && ((state == ST_IDLE) || (gap_cnt == '0));

    always_comb begin
        grant = '0;
        if (fire) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            ovf_set[i] = req_pls[i] && !grant[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_pls[i] && !grant[i]) begin
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (!req_pls[i] && grant[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // A fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{N_REQ{ovf_clr}}) | ovf_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            pluse_s  <= 1'b0;
            pluse_id <= '0;
            rr       <= '0;
        end else begin
            pluse_s <= fire;
            if (fire) begin
                state    <= ST_GAP;
                gap_cnt  <= GC_W'(GAP);
                pluse_id <= winner;
                rr       <= ID_W'((int'(winner) + 1) % N_REQ);
            end else if (state == ST_GAP) begin
                if (gap_cnt == '0) begin
                    state <= ST_IDLE;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

    assign busy = (|pend) | (state == ST_GAP);

endmodule

// File: tb/tb_cdc_pulse_arb.sv
// Directed bench for cdc_pulse_arb: stimulus queues expected pulses, a negedge monitor checks them.
module tb_cdc_pulse_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_pls;
    logic       en;
    logic       ovf_clr;
    logic       pluse_s;
    logic [1:0] pluse_id;
    logic       busy;
    logic [3:0] ovf;

    cdc_pulse_arb #(.N_REQ(4), .CNT_W(4), .GAP(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_pls  (req_pls),
        .en       (en),
        .ovf_clr  (ovf_clr),
        .pluse_s  (pluse_s),
        .pluse_id (pluse_id),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_pulse(input int id, input int at);
        exp_t t;
        t.id = id;
        t.at = at;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Monitor: every observed pulse must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pluse_s === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: id %0d at cycle %0d, none expected", pluse_id, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_id", int'(pluse_id), e.id);
                    chk("pulse_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        int e;
        rst     = 1'b1;
        req_pls = '0;
        en      = 1'b1;
        ovf_clr = 1'b0;

        // Reset held while requests toggle
        for (int i = 0; i < 4; i++) begin
            req_pls = 4'(i * 5 + 3);
            tick();
        end
        chk("rst_pluse_s", int'(pluse_s), 0);
        chk("rst_pluse_id", int'(pluse_id), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);
        req_pls = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_pluse_s", int'(pluse_s), 0);

        // Simultaneous burst: ids 0..3, 8 cycles apart
        e = cyc;
        req_pls = 4'b1111;
        for (int k = 0; k < 4; k++) expect_pulse(k, e + 2 + 8 * k);
        tick();
        req_pls = '0;
        wait_to(e + 34);
        chk("burst_idle_busy", int'(busy), 0);
        chk("burst_ovf", int'(ovf), 0);

        // Single request on requester 2
        e = cyc;
        req_pls = 4'b0100;
        expect_pulse(2, e + 2);
        tick();
        req_pls = '0;
        wait_to(e + 9);
        chk("single_busy_in_gap", int'(busy), 1);
        wait_to(e + 10);
        chk("single_busy_done", int'(busy), 0);

        // Fairness and saturation with requesters 0 and 3 held high
        do_reset();
        e = cyc;
        req_pls = 4'b1001;
        for (int k = 0; k < 6; k++) expect_pulse((k % 2 == 0) ? 0 : 3, e + 2 + 8 * k);
        wait_to(e + 16);
        chk("sat_ovf_before", int'(ovf), 0);
        wait_to(e + 17);
        chk("sat_ovf_set", int'(ovf), 9);
        wait_to(e + 19);
        ovf_clr = 1'b1;
        wait_to(e + 20);
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_set", int'(ovf), 9);
        wait_to(e + 33);
        ovf_clr = 1'b1;
        wait_to(e + 34);
        ovf_clr = 1'b0;
        chk("ovf_clr_on_grant", int'(ovf), 8);
        wait_to(e + 35);
        chk("ovf_reset_again", int'(ovf), 9);
        wait_to(e + 50);
        chk("midrst_pulse_high", int'(pluse_s), 1);
        chk("midrst_pulse_id", int'(pluse_id), 0);
        rst = 1'b1;
        #1;
        chk("midrst_pluse_s", int'(pluse_s), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ovf", int'(ovf), 0);
        req_pls = '0;
        tick();
        rst = 1'b0;
        tick();

        // Increment and grant collide on requester 1
        e = cyc;
        req_pls = 4'b0010;
        expect_pulse(1, e + 2);
        expect_pulse(1, e + 10);
        tick();
        tick();
        req_pls = '0;
        wait_to(e + 19);
        chk("collide_busy", int'(busy), 0);
        chk("collide_ovf", int'(ovf), 0);

        // Enable gating; rr points at 2 here
        e = cyc;
        req_pls = 4'b1111;
        expect_pulse(2, e + 2);
        tick();
        req_pls = 4'b0001;
        tick();
        req_pls = '0;
        wait_to(e + 3);
        en = 1'b0;
        wait_to(e + 6);
        en = 1'b1;
        expect_pulse(3, e + 10);
        wait_to(e + 10);
        en = 1'b0;
        wait_to(e + 25);
        chk("en_low_busy", int'(busy), 1);
        chk("en_low_pluse_s", int'(pluse_s), 0);
        wait_to(e + 30);
        en = 1'b1;
        expect_pulse(0, e + 31);
        expect_pulse(1, e + 39);
        expect_pulse(0, e + 47);
        wait_to(e + 56);
        chk("en_drain_busy", int'(busy), 0);
        chk("en_drain_ovf", int'(ovf), 0);

        tick();
        tick();
        chk("pulses_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
